// File: rtl/mul_div_unit.sv
// Sequential signed multiply/divide unit feeding the ZHigh/ZLow result registers.
// MUL uses radix-2 Booth, DIV uses restoring division on magnitudes plus a sign-fix step.
// Results are presented as {z_high, z_low} with a one-cycle done pulse.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_high,
  output logic [WIDTH-1:0] z_low,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // acc: Booth accumulator / partial remainder; mq: multiplier / dividend-quotient
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic               qm1_q, qm1_d;
  // m: sign-extended multiplicand (MUL) or divisor magnitude (DIV)
  logic [WIDTH:0]     m_q, m_d;
  logic               op_q, op_d;
  logic               qneg_q, qneg_d;
  logic               aneg_q, aneg_d;
  logic               dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0]   z_high_q, z_high_d;
  logic [WIDTH-1:0]   z_low_q, z_low_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     booth_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH:0]     b_ext;
  logic [WIDTH:0]     abs_b;
  logic [WIDTH-1:0]   rem_mag;

  // Operand magnitudes; the W-bit unsigned dividend magnitude still holds 2^(W-1)
  assign abs_a   = a_in[WIDTH-1] ? -a_in : a_in;
  assign b_ext   = {b_in[WIDTH-1], b_in};
  assign abs_b   = b_in[WIDTH-1] ? -b_ext : b_ext;

  // Restoring-division trial subtract on the shifted partial remainder
  assign div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
  assign div_diff  = div_shift - m_q;
  assign div_ge    = (div_shift >= m_q);
  assign rem_mag   = acc_q[WIDTH-1:0];

  // Booth add/subtract selected by the current multiplier bit pair
  always_comb begin
    booth_sum = acc_q;
    case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mq_d       = mq_q;
    qm1_d      = qm1_q;
    m_d        = m_q;
    op_d       = op_q;
    qneg_d     = qneg_q;
    aneg_d     = aneg_q;
    dbz_pend_d = dbz_pend_q;
    z_high_d   = z_high_q;
    z_low_d    = z_low_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d       = op;
          dbz_d      = 1'b0;
          cnt_d      = CntW'(WIDTH);
          qneg_d     = a_in[WIDTH-1] ^ b_in[WIDTH-1];
          aneg_d     = a_in[WIDTH-1];
          dbz_pend_d = 1'b0;
          qm1_d      = 1'b0;
          if (op && (b_in == '0)) begin
            // Divide by zero short-circuits straight to result delivery
            acc_d      = {1'b0, a_in};
            mq_d       = '1;
            dbz_pend_d = 1'b1;
            state_d    = StDone;
          end else if (op) begin
            acc_d   = '0;
            mq_d    = abs_a;
            m_d     = abs_b;
            state_d = StRun;
          end else begin
            acc_d   = '0;
            mq_d    = b_in;
            m_d     = {a_in[WIDTH-1], a_in};
            state_d = StRun;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (op_q) begin
          acc_d = div_ge ? div_diff : div_shift;
          mq_d  = {mq_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          mq_d  = {booth_sum[0], mq_q[WIDTH-1:1]};
          qm1_d = mq_q[0];
        end
        if (cnt_q == CntW'(1)) begin
          state_d = op_q ? StFix : StDone;
        end
      end
      StFix: begin
        // Truncating division: quotient sign from xor, remainder follows the dividend
        mq_d    = qneg_q ? -mq_q : mq_q;
        acc_d   = {1'b0, (aneg_q ? -rem_mag : rem_mag)};
        state_d = StDone;
      end
      StDone: begin
        z_high_d = acc_q[WIDTH-1:0];
        z_low_d  = mq_q;
        dbz_d    = dbz_pend_q;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      mq_q       <= '0;
      qm1_q      <= 1'b0;
      m_q        <= '0;
      op_q       <= 1'b0;
      qneg_q     <= 1'b0;
      aneg_q     <= 1'b0;
      dbz_pend_q <= 1'b0;
      z_high_q   <= '0;
      z_low_q    <= '0;
      dbz_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      qm1_q      <= qm1_d;
      m_q        <= m_d;
      op_q       <= op_d;
      qneg_q     <= qneg_d;
      aneg_q     <= aneg_d;
      dbz_pend_q <= dbz_pend_d;
      z_high_q   <= z_high_d;
      z_low_q    <= z_low_d;
      dbz_q      <= dbz_d;
      done_q     <= done_d;
    end
  end

  // Outputs come straight from registers; busy is decoded from the state register only
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign z_high      = z_high_q;
  assign z_low       = z_low_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected results, a monitor
// pops and compares on every done pulse, including the cycle at which it arrives.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] z_high;
  logic [31:0] z_low;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .z_high      (z_high),
    .z_low       (z_low),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one sample 1 time unit after every rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_check++;
          n_fail++;
          $display("FAIL unexpected_done: actual done=1 at cycle %0d required no done", cyc);
        end else begin
          e = sb.pop_front();
          check("z_high", {32'h0, z_high}, {32'h0, e.hi});
          check("z_low", {32'h0, z_low}, {32'h0, e.lo});
          check("div_by_zero", {63'h0, div_by_zero}, {63'h0, e.dbz});
          check("done_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                       input int lat, input bit push);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    if (push) sb.push_back('{hi: ehi, lo: elo, dbz: edbz, due: cyc + 1 + lat});
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      n_check++;
      n_fail++;
      $display("FAIL %s_timeout: actual %0d results outstanding required 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a_in  = '0;
    b_in  = '0;
    @(posedge clk);
    #2;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_z_high", {32'h0, z_high}, 64'h0);
    check("rst_z_low", {32'h0, z_low}, 64'h0);
    check("rst_dbz", {63'h0, div_by_zero}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // MUL 7 x -3, also count busy cycles
    issue(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #2;
    end
    check("busy_cycles", 64'(n), 64'd33);
    wait_idle("mul_7x_m3");

    // MUL extremes
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33, 1'b1);
    wait_idle("mul_min_min");
    issue(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1, 1'b0, 33, 1'b1);
    wait_idle("mul_max_max");

    // DIV sign combinations and the overflow wrap
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b1);
    wait_idle("div_m7_2");
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34, 1'b1);
    wait_idle("div_7_m2");
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, 1'b1);
    wait_idle("div_min_m1");

    // Divide by zero, then a MUL that must clear the flag on acceptance
    issue(1'b1, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1, 1'b1);
    wait_idle("div_zero");
    issue(1'b0, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 33, 1'b1);
    check("dbz_cleared_on_start", {63'h0, div_by_zero}, 64'h0);
    wait_idle("mul_2x3");

    // Start while busy is ignored
    issue(1'b0, 32'd5, 32'd5, 32'h0, 32'd25, 1'b0, 33, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a_in  = 32'd9;
    b_in  = 32'd9;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_idle("mul_5x5");
    repeat (40) @(posedge clk);

    // Start held in the done cycle is accepted back-to-back
    issue(1'b0, 32'd11, 32'd13, 32'h0, 32'd143, 1'b0, 33, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("done_seen_b2b", {63'h0, done}, 64'h1);
    start = 1'b1;
    op    = 1'b0;
    a_in  = 32'd6;
    b_in  = 32'd7;
    sb.push_back('{hi: 32'h0, lo: 32'd42, dbz: 1'b0, due: cyc + 1 + 33});
    @(posedge clk);
    #2;
    check("busy_after_b2b", {63'h0, busy}, 64'h1);
    start = 1'b0;
    wait_idle("mul_6x7");

    // Asynchronous reset in the middle of a DIV
    issue(1'b1, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, 34, 1'b0);
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_done", {63'h0, done}, 64'h0);
    check("midrst_z_high", {32'h0, z_high}, 64'h0);
    check("midrst_z_low", {32'h0, z_low}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(posedge clk);
    issue(1'b0, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 33, 1'b1);
    wait_idle("mul_3x4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
